resamp_regs_mc: RTL and testbench
=================================

Name: resamp_regs_mc

Overview:
Multi-channel, clocked successor to the resampler control register bank. Holds per-channel shadow copies of resampler rate, AU rate, AU decimation, AU shift and AU enable, written over the processor bus with byte enables. Shadow values transfer atomically into active registers on a commit: either at the channel's next sample-boundary strobe, or immediately when forced. Sits between the bus decoder and NUM_CH resampler datapaths. Multi-byte rate changes never reach a datapath half-written or mid-sample.

Parameters:
NUM_CH, 2, number of resampler channels (1..8)
RATE_W, 32, width of resampleRate and auResampleRate
DEC_W, 15, width of auDecimation
SHIFT_W, 6, width of auShift
ADDR_W, 12, bus address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cs  in  1  block select from bus decoder
wr  in  1  write strobe, one clk wide, qualified by cs
rd  in  1  read strobe, one clk wide, qualified by cs
be  in  4  byte enables for dataIn[31:0]
addr  in  ADDR_W  byte address, addr[1:0] ignored
dataIn  in  32  write data
dataOut  out  32  registered read data
rdValid  out  1  one-cycle pulse, dataOut valid
chSync  in  NUM_CH  per-channel sample-boundary strobe
resampleRate  out  NUM_CH*RATE_W  active rates, channel 0 in LSBs
auResampleRate  out  NUM_CH*RATE_W  active AU rates
auDecimation  out  NUM_CH*DEC_W  active AU decimation
auShift  out  NUM_CH*SHIFT_W  active AU shift
auEnable  out  NUM_CH  active AU enable
commitPending  out  NUM_CH  commit armed, waiting for chSync
commitDone  out  NUM_CH  one-cycle pulse when active registers load

Behaviour:
- Reset (async assert, sync deassert handled upstream): all shadow and active registers are 0, pending 0, commitDone 0, dataOut 0, rdValid 0.
- Address map:
  - Channel block base = ch*0x20, for ch < NUM_CH.
  - Shadow registers: 0x00 RATE, 0x04 AURATE, 0x08 AUDEC, 0x0C AUSHIFT, 0x10 AUENABLE.
  - 0x14 CTRL. Write: bit0 arms a commit, bit1 forces an immediate commit. Read: {30'b0, pending, auEnable_active}.
  - 0x18 active RATE readback, 0x1C active AURATE readback. Both read-only.
- Writes:
  - On a clk edge with cs&wr, each enabled byte of the shadow register is updated.
  - Bits beyond the field width are ignored.
  - AUSHIFT and AUENABLE use be[0] only. AUDEC uses be[1:0].
  - Writes to read-only or unmapped addresses, or ch >= NUM_CH, have no effect.
- Reads:
  - cs&rd in cycle N gives dataOut and rdValid=1 in cycle N+1.
  - Unused bits read 0. Unmapped addresses read 32'h0.
  - dataOut holds its value when rdValid=0.
  - A read and a write in the same cycle to the same register return the pre-write value.
- Per-channel commit FSM, states IDLE and ARMED:
  - IDLE -> ARMED on a CTRL write with bit0=1 and be[0]=1.
  - ARMED -> IDLE on chSync[ch]=1. That edge loads active <= shadow for all five fields, and commitDone pulses in the following cycle.
  - An arm request and chSync in the same cycle: the request arms, and the load happens at the next chSync, not this one.
  - chSync while IDLE: no effect.
  - Re-arm while ARMED: stays ARMED, no extra load.
  - Force (bit1=1, any state) loads active <= shadow on that edge, goes to IDLE and pulses commitDone. Force wins over bit0 in the same write.
  - Shadow writes while ARMED are allowed. The load takes the shadow value present at the chSync edge.
  - A shadow write and the load in the same cycle: the load uses the pre-write shadow value.
  - commitPending = (state == ARMED).
- Channels are fully independent; a single force affects only the addressed channel.

Decomposition:
- Shared package resamp_pkg: register offset constants (OFS_RATE, OFS_AURATE, OFS_AUDEC, OFS_AUSHIFT, OFS_AUEN, OFS_CTRL, OFS_ACT_RATE, OFS_ACT_AURATE), CH_STRIDE=0x20, and the CTRL bit indices.
- One sub-module, resamp_chan_regs, instantiated NUM_CH times via generate. It holds the shadow and active registers, the FSM and the per-channel readback mux.
- The top level decodes the channel index, muxes read data and registers the output.

Test Plan:
- Reset: assert reset_n=0 mid-traffic -> all outputs 0, commitPending=0; any read of 0x00 afterwards returns 0.
- Byte-enable write: write ch1 RATE 0xDEADBEEF with be=4'b0101 over reset state -> shadow readback 0x00AD00EF one cycle after rd; active resampleRate[63:32] unchanged.
- Armed commit: ch0 RATE=0x12345678, write CTRL=1 -> commitPending[0]=1. Pulse chSync[0] -> resampleRate[31:0]=0x12345678, commitDone[0] one cycle later, pending cleared.
- Simultaneous arm and chSync on ch0 -> no load that cycle; load occurs on the next chSync[0].
- Force: ch1 AUSHIFT=0x3F, AUDEC=0x7FFF, write CTRL=3 -> immediate load, auShift=0x3F, auDecimation=0x7FFF, commitPending[1]=0; ch0 outputs unchanged.
- Unmapped and out-of-range accesses: read 0x40 with NUM_CH=2 -> dataOut=0, rdValid=1; write 0x18 -> active rate unchanged.

Source files
------------

// File: rtl/resamp_pkg.sv
// Shared register map, commit control bits and helpers for the
// multi-channel resampler control register bank.
package resamp_pkg;

   localparam logic [4:0] OFS_RATE       = 5'h00;
   localparam logic [4:0] OFS_AURATE     = 5'h04;
   localparam logic [4:0] OFS_AUDEC      = 5'h08;
   localparam logic [4:0] OFS_AUSHIFT    = 5'h0C;
   localparam logic [4:0] OFS_AUEN       = 5'h10;
   localparam logic [4:0] OFS_CTRL       = 5'h14;
   localparam logic [4:0] OFS_ACT_RATE   = 5'h18;
   localparam logic [4:0] OFS_ACT_AURATE = 5'h1C;

   localparam int unsigned CH_STRIDE  = 32'h20;
   localparam int unsigned CTRL_ARM   = 0;
   localparam int unsigned CTRL_FORCE = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } commit_state_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] din,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int unsigned b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = din[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/resamp_chan_regs.sv
// One resampler channel: shadow/active register pairs, the commit FSM
// and the channel-local readback mux.
module resamp_chan_regs
   import resamp_pkg::*;
#(
   parameter int unsigned RATE_W  = 32,
   parameter int unsigned DEC_W   = 15,
   parameter int unsigned SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_wr,
   input  logic [4:0]         i_ofs,
   input  logic [3:0]         i_be,
   input  logic [31:0]        i_data,
   input  logic               i_sync,
   output logic [RATE_W-1:0]  o_rate,
   output logic [RATE_W-1:0]  o_aurate,
   output logic [DEC_W-1:0]   o_audec,
   output logic [SHIFT_W-1:0] o_aushift,
   output logic               o_auen,
   output logic               o_pending,
   output logic               o_done,
   output logic [31:0]        o_rdata
);

   logic [RATE_W-1:0]  r_sh_rate, r_sh_aurate, r_act_rate, r_act_aurate;
   logic [DEC_W-1:0]   r_sh_audec, r_act_audec;
   logic [SHIFT_W-1:0] r_sh_aushift, r_act_aushift;
   logic               r_sh_auen, r_act_auen;
   logic               r_done;
   commit_state_t      r_state, w_next;
   logic               w_ctrl_wr, w_arm, w_force, w_load;

   assign w_ctrl_wr = i_wr && (i_ofs == OFS_CTRL) && i_be[0];
   assign w_arm     = w_ctrl_wr && i_data[CTRL_ARM];
   assign w_force   = w_ctrl_wr && i_data[CTRL_FORCE];

   // Force beats arm; a fresh arm request masks a coincident chSync.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      if (w_force) begin
         w_load = 1'b1;
         w_next = ST_IDLE;
      end else if (w_arm) begin
         w_next = ST_ARMED;
      end else if (r_state == ST_ARMED && i_sync) begin
         w_load = 1'b1;
         w_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_load;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sh_rate    <= '0;
         r_sh_aurate  <= '0;
         r_sh_audec   <= '0;
         r_sh_aushift <= '0;
         r_sh_auen    <= 1'b0;
      end else if (i_wr) begin
         case (i_ofs)
            OFS_RATE:    r_sh_rate    <= RATE_W'(be_merge(32'(r_sh_rate), i_data, i_be));
            OFS_AURATE:  r_sh_aurate  <= RATE_W'(be_merge(32'(r_sh_aurate), i_data, i_be));
            OFS_AUDEC:   r_sh_audec   <= DEC_W'(be_merge(32'(r_sh_audec), i_data, i_be & 4'b0011));
            OFS_AUSHIFT: r_sh_aushift <= SHIFT_W'(be_merge(32'(r_sh_aushift), i_data, i_be & 4'b0001));
            OFS_AUEN:    if (i_be[0]) r_sh_auen <= i_data[0];
            default: ;
         endcase
      end
   end

   // Active side samples the shadow before any same-edge shadow write lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_act_rate    <= '0;
         r_act_aurate  <= '0;
         r_act_audec   <= '0;
         r_act_aushift <= '0;
         r_act_auen    <= 1'b0;
      end else if (w_load) begin
         r_act_rate    <= r_sh_rate;
         r_act_aurate  <= r_sh_aurate;
         r_act_audec   <= r_sh_audec;
         r_act_aushift <= r_sh_aushift;
         r_act_auen    <= r_sh_auen;
      end
   end

   always_comb begin
      o_rdata = '0;
      case (i_ofs)
         OFS_RATE:       o_rdata = 32'(r_sh_rate);
         OFS_AURATE:     o_rdata = 32'(r_sh_aurate);
         OFS_AUDEC:      o_rdata = 32'(r_sh_audec);
         OFS_AUSHIFT:    o_rdata = 32'(r_sh_aushift);
         OFS_AUEN:       o_rdata = {31'b0, r_sh_auen};
         OFS_CTRL:       o_rdata = {30'b0, (r_state == ST_ARMED), r_act_auen};
         OFS_ACT_RATE:   o_rdata = 32'(r_act_rate);
         OFS_ACT_AURATE: o_rdata = 32'(r_act_aurate);
         default:        o_rdata = '0;
      endcase
   end

   assign o_rate    = r_act_rate;
   assign o_aurate  = r_act_aurate;
   assign o_audec   = r_act_audec;
   assign o_aushift = r_act_aushift;
   assign o_auen    = r_act_auen;
   assign o_pending = (r_state == ST_ARMED);
   assign o_done    = r_done;

endmodule

// File: rtl/resamp_regs_mc.sv
// Multi-channel resampler control register bank: channel decode,
// per-channel register blocks and registered bus read path.
module resamp_regs_mc
   import resamp_pkg::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned RATE_W  = 32,
   parameter int unsigned DEC_W   = 15,
   parameter int unsigned SHIFT_W = 6,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cs,
   input  logic                        wr,
   input  logic                        rd,
   input  logic [3:0]                  be,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [31:0]                 dataIn,
   output logic [31:0]                 dataOut,
   output logic                        rdValid,
   input  logic [NUM_CH-1:0]           chSync,
   output logic [NUM_CH*RATE_W-1:0]    resampleRate,
   output logic [NUM_CH*RATE_W-1:0]    auResampleRate,
   output logic [NUM_CH*DEC_W-1:0]     auDecimation,
   output logic [NUM_CH*SHIFT_W-1:0]   auShift,
   output logic [NUM_CH-1:0]           auEnable,
   output logic [NUM_CH-1:0]           commitPending,
   output logic [NUM_CH-1:0]           commitDone
);

   localparam int unsigned CH_LSB = $clog2(CH_STRIDE);
   localparam int unsigned CH_W   = ADDR_W - CH_LSB;

   logic [CH_W-1:0] w_ch;
   logic [4:0]      w_ofs;
   logic [31:0]     w_rdata [NUM_CH];
   logic [31:0]     w_rsel;
   logic [31:0]     r_dout;
   logic            r_rvalid;
   logic            w_unused_addr;

   assign w_ch          = addr[ADDR_W-1:CH_LSB];
   assign w_ofs         = {addr[CH_LSB-1:2], 2'b00};
   assign w_unused_addr = ^addr[1:0];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      resamp_chan_regs #(
         .RATE_W  (RATE_W),
         .DEC_W   (DEC_W),
         .SHIFT_W (SHIFT_W)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .i_wr      (cs && wr && (w_ch == CH_W'(g))),
         .i_ofs     (w_ofs),
         .i_be      (be),
         .i_data    (dataIn),
         .i_sync    (chSync[g]),
         .o_rate    (resampleRate[g*RATE_W +: RATE_W]),
         .o_aurate  (auResampleRate[g*RATE_W +: RATE_W]),
         .o_audec   (auDecimation[g*DEC_W +: DEC_W]),
         .o_aushift (auShift[g*SHIFT_W +: SHIFT_W]),
         .o_auen    (auEnable[g]),
         .o_pending (commitPending[g]),
         .o_done    (commitDone[g]),
         .o_rdata   (w_rdata[g])
      );
   end

   // Channel indices at or beyond NUM_CH match nothing and read as zero.
   always_comb begin
      w_rsel = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (w_ch == CH_W'(i)) w_rsel = w_rdata[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dout   <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= cs && rd;
         if (cs && rd) r_dout <= w_rsel;
      end
   end

   assign dataOut = r_dout;
   assign rdValid = r_rvalid;

endmodule

// File: tb/tb_resamp_regs_mc.sv
// Directed self-checking bench for resamp_regs_mc (NUM_CH=2).
module tb_resamp_regs_mc;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs, wr, rd;
   logic [3:0]  be;
   logic [11:0] addr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        rdValid;
   logic [1:0]  chSync;
   logic [63:0] resampleRate, auResampleRate;
   logic [29:0] auDecimation;
   logic [11:0] auShift;
   logic [1:0]  auEnable, commitPending, commitDone;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   resamp_regs_mc #(
      .NUM_CH  (2),
      .RATE_W  (32),
      .DEC_W   (15),
      .SHIFT_W (6),
      .ADDR_W  (12)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cs             (cs),
      .wr             (wr),
      .rd             (rd),
      .be             (be),
      .addr           (addr),
      .dataIn         (dataIn),
      .dataOut        (dataOut),
      .rdValid        (rdValid),
      .chSync         (chSync),
      .resampleRate   (resampleRate),
      .auResampleRate (auResampleRate),
      .auDecimation   (auDecimation),
      .auShift        (auShift),
      .auEnable       (auEnable),
      .commitPending  (commitPending),
      .commitDone     (commitDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drives one bus/sync cycle from a negedge; returns at the next negedge.
   task automatic bus_cycle(input logic w, input logic r, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] b, input logic [1:0] s);
      cs = w | r; wr = w; rd = r; addr = a; dataIn = d; be = b; chSync = s;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; rd = 1'b0; chSync = 2'b00;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      bus_cycle(1'b1, 1'b0, a, d, b, 2'b00);
   endtask

   task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
      bus_cycle(1'b0, 1'b1, a, 32'h0, 4'h0, 2'b00);
      check({tag, "_vld"}, {31'b0, rdValid}, 32'h1);
      check(tag, dataOut, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rate0"}, resampleRate[31:0], 32'h0);
      check({tag, "_rate1"}, resampleRate[63:32], 32'h0);
      check({tag, "_aurate"}, auResampleRate[31:0] | auResampleRate[63:32], 32'h0);
      check({tag, "_misc"}, {auDecimation, auEnable}, 32'h0);
      check({tag, "_shift"}, {20'h0, auShift}, 32'h0);
      check({tag, "_flags"}, {26'h0, commitPending, commitDone, rdValid, 1'b0}, 32'h0);
      check({tag, "_dout"}, dataOut, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      cs = 1'b0; wr = 1'b0; rd = 1'b0; be = 4'h0; addr = '0; dataIn = '0; chSync = 2'b00;
      #3;
      check_all_zero("rst");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Byte-enabled shadow write on ch1
      bus_write(12'h020, 32'hDEADBEEF, 4'b0101);
      read_check("be_rate1", 12'h020, 32'h00AD00EF);
      check("be_act1", resampleRate[63:32], 32'h0);

      // Armed commit on ch0
      bus_write(12'h000, 32'h12345678, 4'hF);
      bus_write(12'h014, 32'h1, 4'b0001);
      check("arm_pend", {30'h0, commitPending}, 32'h1);
      check("arm_noload", resampleRate[31:0], 32'h0);
      read_check("arm_ctrl", 12'h014, 32'h2);
      bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 2'b01);
      check("sync_rate", resampleRate[31:0], 32'h12345678);
      check("sync_done", {30'h0, commitDone}, 32'h1);
      check("sync_pend", {30'h0, commitPending}, 32'h0);
      @(negedge clk);
      check("done_pulse", {30'h0, commitDone}, 32'h0);

      // chSync while idle does nothing
      bus_write(12'h000, 32'h55555555, 4'hF);
      bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 2'b01);
      check("idle_sync_rate", resampleRate[31:0], 32'h12345678);
      check("idle_sync_done", {30'h0, commitDone}, 32'h0);

      // Arm and chSync together: arm only, load on next sync
      bus_write(12'h000, 32'hCAFEF00D, 4'hF);
      bus_cycle(1'b1, 1'b0, 12'h014, 32'h1, 4'b0001, 2'b01);
      check("simul_pend", {30'h0, commitPending}, 32'h1);
      check("simul_rate", resampleRate[31:0], 32'h12345678);
      check("simul_done", {30'h0, commitDone}, 32'h0);
      bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 2'b01);
      check("simul_load", resampleRate[31:0], 32'hCAFEF00D);
      check("simul_ldone", {30'h0, commitDone}, 32'h1);

      // Shadow write on the load edge: load takes pre-write value
      bus_write(12'h014, 32'h1, 4'b0001);
      bus_cycle(1'b1, 1'b0, 12'h000, 32'h0BADF00D, 4'hF, 2'b01);
      check("prewr_rate", resampleRate[31:0], 32'hCAFEF00D);
      check("prewr_done", {30'h0, commitDone}, 32'h1);
      bus_write(12'h014, 32'h1, 4'b0001);
      bus_cycle(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 2'b01);
      check("postwr_rate", resampleRate[31:0], 32'h0BADF00D);

      // Forced commit on ch1 only
      bus_write(12'h02C, 32'h000000FF, 4'b0001);
      bus_write(12'h02C, 32'h00000000, 4'b1110);
      read_check("shift_be", 12'h02C, 32'h3F);
      bus_write(12'h028, 32'hFFFFFFFF, 4'hF);
      bus_write(12'h030, 32'h1, 4'b0001);
      bus_write(12'h034, 32'h3, 4'b0001);
      check("frc_shift", {26'h0, auShift[11:6]}, 32'h3F);
      check("frc_dec", {17'h0, auDecimation[29:15]}, 32'h7FFF);
      check("frc_en", {30'h0, auEnable}, 32'h2);
      check("frc_pend", {30'h0, commitPending}, 32'h0);
      check("frc_done", {30'h0, commitDone}, 32'h2);
      check("frc_rate1", resampleRate[63:32], 32'h00AD00EF);
      check("frc_ch0rate", resampleRate[31:0], 32'h0BADF00D);
      check("frc_ch0misc", {11'h0, auShift[5:0], auDecimation[14:0]}, 32'h0);
      read_check("frc_actrd", 12'h038, 32'h00AD00EF);
      read_check("frc_ctrl", 12'h034, 32'h1);

      // Unmapped / out-of-range / read-only
      read_check("unmap_rd", 12'h040, 32'h0);
      bus_write(12'h018, 32'h0, 4'hF);
      check("ro_wr", resampleRate[31:0], 32'h0BADF00D);
      bus_write(12'h040, 32'hFFFFFFFF, 4'hF);
      read_check("oor_wr", 12'h000, 32'h0BADF00D);

      // Read and write of the same register in one cycle
      bus_write(12'h004, 32'h11111111, 4'hF);
      bus_cycle(1'b1, 1'b1, 12'h004, 32'h22222222, 4'hF, 2'b00);
      check("rw_old", dataOut, 32'h11111111);
      read_check("rw_new", 12'h004, 32'h22222222);
      @(negedge clk);
      check("hold_vld", {31'h0, rdValid}, 32'h0);
      check("hold_dout", dataOut, 32'h22222222);

      // Asynchronous reset in the middle of a write
      cs = 1'b1; wr = 1'b1; addr = 12'h000; dataIn = 32'h77777777; be = 4'hF;
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      read_check("rst_rd0", 12'h000, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
